rv32c_fetch_queue: RTL and testbench

Parametrised halfword-granular instruction fetch queue for the RV32C front end, sitting between instruction memory and the decompressor/decode stage. It generates word-aligned fetch addresses, buffers returned 32-bit words as a circular queue of halfwords, and emits one instruction per handshake (16-bit compressed or 32-bit, including 32-bit instructions straddling fetch words) with its PC and next PC. It supports configurable depth, a compressed-disable mode, and single-cycle redirect to any halfword-aligned target.

---
 rtl/rv32c_fetch_queue_if.sv | 32 +++
 rtl/rv32c_fetch_queue.sv | 94 +++++++++
 tb/tb_rv32c_fetch_queue.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32c_fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle for the RV32C fetch queue.
// The queue takes the slave view; the memory/decode environment takes the master view.
interface rv32c_fetch_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_addr;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          redirect_en;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic          out_c;
  logic [31:0]   out_pc;
  logic [31:0]   out_npc;
  logic          out_ill;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_data, redirect_en, redirect_pc, out_ready,
    input  fetch_addr, in_ready, out_valid, out_inst, out_c, out_pc, out_npc, out_ill, count
  );

  modport slave (
    input  in_valid, in_data, redirect_en, redirect_pc, out_ready,
    output fetch_addr, in_ready, out_valid, out_inst, out_c, out_pc, out_npc, out_ill, count
  );
endinterface

// File: rtl/rv32c_fetch_queue.sv
// Halfword-granular RV32C fetch queue: accepts word-aligned fetch words and
// hands out one 16-bit or 32-bit instruction per handshake with its PC.
module rv32c_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter int          DEPTH    = 8,
  parameter bit          C_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  rv32c_fetch_queue_if.slave fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] cnt;
  logic [31:0]   faddr;
  logic [31:0]   head_pc;
  logic          skip;

  logic [15:0]   hw0;
  logic [15:0]   hw1;
  logic          is_c;
  logic          head_ok;
  logic          push;
  logic          pop;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;
  logic [31:0]   npc;
  logic [31:1]   tgt;
  logic          unused_bits;

  assign unused_bits = fq.redirect_pc[0];

  // An empty queue reports a 32-bit head so reset shows out_c = 0 and npc = pc + 4.
  assign hw0     = mem[rptr];
  assign hw1     = mem[rptr + AW'(1)];
  assign is_c    = C_EN && (cnt != '0) && (hw0[1:0] != 2'b11);
  assign head_ok = is_c || (cnt >= CW'(2));
  assign npc     = head_pc + (is_c ? 32'd2 : 32'd4);

  assign fq.fetch_addr = faddr;
  assign fq.in_ready   = (cnt <= CW'(DEPTH - 2));
  assign fq.out_valid  = head_ok && !fq.redirect_en;
  assign fq.out_inst   = (cnt == '0) ? 32'h0 : (is_c ? {16'h0, hw0} : {hw1, hw0});
  assign fq.out_c      = is_c;
  assign fq.out_pc     = head_pc;
  assign fq.out_npc    = npc;
  assign fq.out_ill    = !C_EN && (cnt != '0) && (hw0[1:0] != 2'b11);
  assign fq.count      = cnt;

  assign push   = fq.in_valid && fq.in_ready && !fq.redirect_en;
  assign pop    = fq.out_valid && fq.out_ready;
  assign push_n = skip ? CW'(1) : CW'(2);
  assign pop_n  = is_c ? CW'(1) : CW'(2);
  assign tgt    = rst ? RESET_PC[31:1] : fq.redirect_pc[31:1];

  // Reset behaves exactly like a redirect to RESET_PC; with C_EN = 0 the target drops to its word.
  always_ff @(posedge clk) begin
    if (rst || fq.redirect_en) begin
      rptr    <= '0;
      wptr    <= '0;
      cnt     <= '0;
      head_pc <= C_EN ? {tgt[31:1], 1'b0} : {tgt[31:2], 2'b00};
      faddr   <= {tgt[31:2], 2'b00};
      skip    <= C_EN && tgt[1];
    end else begin
      if (push) begin
        wptr  <= wptr + push_n[AW-1:0];
        faddr <= faddr + 32'd4;
        skip  <= 1'b0;
      end
      if (pop) begin
        rptr    <= rptr + pop_n[AW-1:0];
        head_pc <= npc;
      end
      cnt <= cnt + (push ? push_n : CW'(0)) - (pop ? pop_n : CW'(0));
    end
  end

  // A skipped word contributes only its upper halfword (redirect into the middle of a word).
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      if (skip) begin
        mem[wptr] <= fq.in_data[31:16];
      end else begin
        mem[wptr]          <= fq.in_data[15:0];
        mem[wptr + AW'(1)] <= fq.in_data[31:16];
      end
    end
  end
endmodule

// File: tb/tb_rv32c_fetch_queue.sv
// Bench for rv32c_fetch_queue: directed scenarios on a DEPTH=4 C-enabled queue and a
// C-disabled queue, then a randomized run checked against a halfword-queue reference.
module tb_rv32c_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rv32c_fetch_queue_if #(.DEPTH(4)) qa ();
  rv32c_fetch_queue_if #(.DEPTH(8)) qb ();

  rv32c_fetch_queue #(.RESET_PC(32'h80000000), .DEPTH(4), .C_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .fq(qa)
  );
  rv32c_fetch_queue #(.RESET_PC(32'h80000000), .DEPTH(8), .C_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .fq(qb)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    qa.in_valid = 0; qa.in_data = '0; qa.redirect_en = 0; qa.redirect_pc = '0; qa.out_ready = 0;
    qb.in_valid = 0; qb.in_data = '0; qb.redirect_en = 0; qb.redirect_pc = '0; qb.out_ready = 0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1; tick(); tick(); rst = 0; #4;
    checks++; if ({qa.out_valid, qa.in_ready, qa.out_c, qa.out_ill} !== 4'b0100) begin errors++; $display("[TB] FAIL reset_a_flags got=%b exp=%b", {qa.out_valid, qa.in_ready, qa.out_c, qa.out_ill}, 4'b0100); end
    checks++; if ({qa.out_pc, qa.out_npc, qa.fetch_addr} !== {32'h80000000, 32'h80000004, 32'h80000000}) begin errors++; $display("[TB] FAIL reset_a_pcs got=%h exp=%h", {qa.out_pc, qa.out_npc, qa.fetch_addr}, {32'h80000000, 32'h80000004, 32'h80000000}); end
    checks++; if (qa.count !== 3'd0) begin errors++; $display("[TB] FAIL reset_a_count got=%0d exp=0", qa.count); end
    checks++; if ({qb.out_valid, qb.in_ready, qb.out_c, qb.out_ill, qb.count} !== {4'b0100, 4'd0}) begin errors++; $display("[TB] FAIL reset_b_flags got=%b exp=%b", {qb.out_valid, qb.in_ready, qb.out_c, qb.out_ill, qb.count}, {4'b0100, 4'd0}); end
    checks++; if ({qb.out_pc, qb.out_npc, qb.fetch_addr} !== {32'h80000000, 32'h80000004, 32'h80000000}) begin errors++; $display("[TB] FAIL reset_b_pcs got=%h exp=%h", {qb.out_pc, qb.out_npc, qb.fetch_addr}, {32'h80000000, 32'h80000004, 32'h80000000}); end
    tick();
  endtask

  task automatic test_basic();
    qa.in_valid = 1; qa.in_data = 32'h00000013; #4;
    checks++; if ({qa.in_ready, qa.fetch_addr} !== {1'b1, 32'h80000000}) begin errors++; $display("[TB] FAIL basic_first_push got=%h exp=%h", {qa.in_ready, qa.fetch_addr}, {1'b1, 32'h80000000}); end
    tick();
    qa.in_data = 32'h00A00093; #4;
    checks++; if ({qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc} !== {2'b10, 32'h00000013, 32'h80000000, 32'h80000004}) begin errors++; $display("[TB] FAIL basic_head0 got=%h exp=%h", {qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc}, {2'b10, 32'h00000013, 32'h80000000, 32'h80000004}); end
    checks++; if ({qa.count, qa.fetch_addr} !== {3'd2, 32'h80000004}) begin errors++; $display("[TB] FAIL basic_count1 got=%h exp=%h", {qa.count, qa.fetch_addr}, {3'd2, 32'h80000004}); end
    tick();
    qa.in_valid = 0; qa.out_ready = 1; #4;
    checks++; if ({qa.count, qa.in_ready} !== {3'd4, 1'b0}) begin errors++; $display("[TB] FAIL basic_full got=%h exp=%h", {qa.count, qa.in_ready}, {3'd4, 1'b0}); end
    tick(); #4;
    checks++; if ({qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc} !== {2'b10, 32'h00A00093, 32'h80000004, 32'h80000008}) begin errors++; $display("[TB] FAIL basic_head1 got=%h exp=%h", {qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc}, {2'b10, 32'h00A00093, 32'h80000004, 32'h80000008}); end
    tick();
    qa.out_ready = 0; #4;
    checks++; if ({qa.count, qa.out_valid, qa.out_pc} !== {3'd0, 1'b0, 32'h80000008}) begin errors++; $display("[TB] FAIL basic_drained got=%h exp=%h", {qa.count, qa.out_valid, qa.out_pc}, {3'd0, 1'b0, 32'h80000008}); end
    tick();
  endtask

  task automatic test_mixed();
    qa.in_valid = 1; qa.in_data = 32'h00134505; qa.out_ready = 0; #4; tick();
    qa.in_valid = 0; qa.out_ready = 1; #4;
    checks++; if ({qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc} !== {2'b11, 32'h00004505, 32'h80000008, 32'h8000000A}) begin errors++; $display("[TB] FAIL mixed_c got=%h exp=%h", {qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc}, {2'b11, 32'h00004505, 32'h80000008, 32'h8000000A}); end
    tick();
    qa.in_valid = 1; qa.in_data = 32'hABCD0000; #4;
    checks++; if ({qa.out_valid, qa.count, qa.out_pc} !== {1'b0, 3'd1, 32'h8000000A}) begin errors++; $display("[TB] FAIL mixed_half got=%h exp=%h", {qa.out_valid, qa.count, qa.out_pc}, {1'b0, 3'd1, 32'h8000000A}); end
    tick();
    qa.in_valid = 0; qa.out_ready = 0; #4;
    checks++; if ({qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc, qa.count} !== {2'b10, 32'h00000013, 32'h8000000A, 32'h8000000E, 3'd3}) begin errors++; $display("[TB] FAIL mixed_straddle got=%h exp=%h", {qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc, qa.count}, {2'b10, 32'h00000013, 32'h8000000A, 32'h8000000E, 3'd3}); end
    tick();
    qa.out_ready = 1; #4; tick(); #4;
    checks++; if ({qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc} !== {2'b11, 32'h0000ABCD, 32'h8000000E, 32'h80000010}) begin errors++; $display("[TB] FAIL mixed_tail got=%h exp=%h", {qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc}, {2'b11, 32'h0000ABCD, 32'h8000000E, 32'h80000010}); end
    tick();
    qa.out_ready = 0; #4;
    checks++; if (qa.count !== 3'd0) begin errors++; $display("[TB] FAIL mixed_drained got=%0d exp=0", qa.count); end
    tick();
  endtask

  task automatic test_wrap_full();
    qa.in_valid = 1; qa.in_data = 32'h00934505; #4; tick();
    qa.in_data = 32'h001300A0; #4; tick();
    qa.in_data = 32'h80820000; #4;
    checks++; if ({qa.count, qa.in_ready, qa.fetch_addr} !== {3'd4, 1'b0, 32'h80000018}) begin errors++; $display("[TB] FAIL wrap_full got=%h exp=%h", {qa.count, qa.in_ready, qa.fetch_addr}, {3'd4, 1'b0, 32'h80000018}); end
    tick(); #4;
    checks++; if ({qa.count, qa.fetch_addr} !== {3'd4, 32'h80000018}) begin errors++; $display("[TB] FAIL wrap_blocked got=%h exp=%h", {qa.count, qa.fetch_addr}, {3'd4, 32'h80000018}); end
    tick();
    qa.in_valid = 0; qa.out_ready = 1; #4;
    checks++; if ({qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc} !== {2'b11, 32'h00004505, 32'h80000010}) begin errors++; $display("[TB] FAIL wrap_i0 got=%h exp=%h", {qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc}, {2'b11, 32'h00004505, 32'h80000010}); end
    tick(); #4;
    checks++; if ({qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc} !== {2'b10, 32'h00A00093, 32'h80000012, 32'h80000016}) begin errors++; $display("[TB] FAIL wrap_i1 got=%h exp=%h", {qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc}, {2'b10, 32'h00A00093, 32'h80000012, 32'h80000016}); end
    tick();
    qa.in_valid = 1; qa.in_data = 32'h80820000; #4;
    checks++; if ({qa.out_valid, qa.count, qa.in_ready} !== {1'b0, 3'd1, 1'b1}) begin errors++; $display("[TB] FAIL wrap_half got=%h exp=%h", {qa.out_valid, qa.count, qa.in_ready}, {1'b0, 3'd1, 1'b1}); end
    tick();
    qa.in_valid = 0; qa.out_ready = 0; #4;
    checks++; if ({qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc, qa.count} !== {2'b10, 32'h00000013, 32'h80000016, 32'h8000001A, 3'd3}) begin errors++; $display("[TB] FAIL wrap_straddle got=%h exp=%h", {qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc, qa.count}, {2'b10, 32'h00000013, 32'h80000016, 32'h8000001A, 3'd3}); end
    tick();
    qa.out_ready = 1; #4; tick(); #4;
    checks++; if ({qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc} !== {2'b11, 32'h00008082, 32'h8000001A, 32'h8000001C}) begin errors++; $display("[TB] FAIL wrap_last got=%h exp=%h", {qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc}, {2'b11, 32'h00008082, 32'h8000001A, 32'h8000001C}); end
    tick();
    qa.out_ready = 0; #4;
    checks++; if ({qa.count, qa.fetch_addr, qa.out_pc} !== {3'd0, 32'h8000001C, 32'h8000001C}) begin errors++; $display("[TB] FAIL wrap_drained got=%h exp=%h", {qa.count, qa.fetch_addr, qa.out_pc}, {3'd0, 32'h8000001C, 32'h8000001C}); end
    tick();
  endtask

  task automatic test_redirect();
    qa.in_valid = 1; qa.in_data = 32'h00130013; #4; tick();
    qa.redirect_en = 1; qa.redirect_pc = 32'h80000102; qa.in_data = 32'hDEADBEEF; qa.out_ready = 1; #4;
    checks++; if ({qa.out_valid, qa.in_ready, qa.count} !== {2'b01, 3'd2}) begin errors++; $display("[TB] FAIL redir_cycle got=%h exp=%h", {qa.out_valid, qa.in_ready, qa.count}, {2'b01, 3'd2}); end
    tick();
    qa.redirect_en = 0; qa.in_valid = 0; qa.out_ready = 0; #4;
    checks++; if ({qa.count, qa.out_valid, qa.fetch_addr, qa.out_pc} !== {3'd0, 1'b0, 32'h80000100, 32'h80000102}) begin errors++; $display("[TB] FAIL redir_after got=%h exp=%h", {qa.count, qa.out_valid, qa.fetch_addr, qa.out_pc}, {3'd0, 1'b0, 32'h80000100, 32'h80000102}); end
    tick();
    qa.in_valid = 1; qa.in_data = 32'h45050001; #4; tick();
    qa.in_valid = 0; #4;
    checks++; if ({qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc, qa.count, qa.fetch_addr} !== {2'b11, 32'h00004505, 32'h80000102, 32'h80000104, 3'd1, 32'h80000104}) begin errors++; $display("[TB] FAIL redir_skip got=%h exp=%h", {qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc, qa.count, qa.fetch_addr}, {2'b11, 32'h00004505, 32'h80000102, 32'h80000104, 3'd1, 32'h80000104}); end
    tick();
    qa.out_ready = 1; #4; tick();
    qa.out_ready = 0; #4;
    checks++; if ({qa.count, qa.out_pc} !== {3'd0, 32'h80000104}) begin errors++; $display("[TB] FAIL redir_drained got=%h exp=%h", {qa.count, qa.out_pc}, {3'd0, 32'h80000104}); end
    tick();
  endtask

  task automatic test_back_to_back();
    qa.in_valid = 1; qa.in_data = 32'h00A00093; #4; tick();
    qa.in_data = 32'h45058082; qa.out_ready = 1; #4;
    checks++; if ({qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc, qa.count, qa.in_ready} !== {2'b10, 32'h00A00093, 32'h80000104, 32'h80000108, 3'd2, 1'b1}) begin errors++; $display("[TB] FAIL b2b_0 got=%h exp=%h", {qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc, qa.count, qa.in_ready}, {2'b10, 32'h00A00093, 32'h80000104, 32'h80000108, 3'd2, 1'b1}); end
    tick();
    qa.in_data = 32'h00A00093; #4;
    checks++; if ({qa.count, qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc} !== {3'd2, 2'b11, 32'h00008082, 32'h80000108, 32'h8000010A}) begin errors++; $display("[TB] FAIL b2b_1 got=%h exp=%h", {qa.count, qa.out_valid, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc}, {3'd2, 2'b11, 32'h00008082, 32'h80000108, 32'h8000010A}); end
    tick();
    qa.in_data = 32'h00130013; #4;
    checks++; if ({qa.count, qa.in_ready, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc} !== {3'd3, 2'b01, 32'h00004505, 32'h8000010A, 32'h8000010C}) begin errors++; $display("[TB] FAIL b2b_2 got=%h exp=%h", {qa.count, qa.in_ready, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc}, {3'd3, 2'b01, 32'h00004505, 32'h8000010A, 32'h8000010C}); end
    tick(); #4;
    checks++; if ({qa.count, qa.in_ready, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc} !== {3'd2, 2'b10, 32'h00A00093, 32'h8000010C, 32'h80000110}) begin errors++; $display("[TB] FAIL b2b_3 got=%h exp=%h", {qa.count, qa.in_ready, qa.out_c, qa.out_inst, qa.out_pc, qa.out_npc}, {3'd2, 2'b10, 32'h00A00093, 32'h8000010C, 32'h80000110}); end
    tick();
    qa.in_valid = 0; #4;
    checks++; if ({qa.count, qa.out_valid, qa.out_inst, qa.out_pc, qa.out_npc} !== {3'd2, 1'b1, 32'h00130013, 32'h80000110, 32'h80000114}) begin errors++; $display("[TB] FAIL b2b_4 got=%h exp=%h", {qa.count, qa.out_valid, qa.out_inst, qa.out_pc, qa.out_npc}, {3'd2, 1'b1, 32'h00130013, 32'h80000110, 32'h80000114}); end
    tick();
    qa.out_ready = 0; #4;
    checks++; if ({qa.count, qa.out_pc} !== {3'd0, 32'h80000114}) begin errors++; $display("[TB] FAIL b2b_drained got=%h exp=%h", {qa.count, qa.out_pc}, {3'd0, 32'h80000114}); end
    tick();
  endtask

  task automatic test_cen0();
    qb.in_valid = 1; qb.in_data = 32'h00004505; #4; tick();
    qb.in_valid = 0; #4;
    checks++; if ({qb.out_valid, qb.out_c, qb.out_ill, qb.out_inst, qb.out_pc, qb.out_npc, qb.count} !== {3'b101, 32'h00004505, 32'h80000000, 32'h80000004, 4'd2}) begin errors++; $display("[TB] FAIL cen0_ill got=%h exp=%h", {qb.out_valid, qb.out_c, qb.out_ill, qb.out_inst, qb.out_pc, qb.out_npc, qb.count}, {3'b101, 32'h00004505, 32'h80000000, 32'h80000004, 4'd2}); end
    tick();
    qb.out_ready = 1; #4; tick();
    qb.out_ready = 0; qb.redirect_en = 1; qb.redirect_pc = 32'h80000006; #4;
    checks++; if (qb.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL cen0_redir_valid got=%b exp=0", qb.out_valid); end
    tick();
    qb.redirect_en = 0; #4;
    checks++; if ({qb.fetch_addr, qb.out_pc, qb.count} !== {32'h80000004, 32'h80000004, 4'd0}) begin errors++; $display("[TB] FAIL cen0_redir got=%h exp=%h", {qb.fetch_addr, qb.out_pc, qb.count}, {32'h80000004, 32'h80000004, 4'd0}); end
    tick();
    qb.in_valid = 1; qb.in_data = 32'h12345678; #4; tick();
    qb.in_valid = 0; #4;
    checks++; if ({qb.out_valid, qb.out_c, qb.out_ill, qb.out_inst, qb.out_npc, qb.count} !== {3'b101, 32'h12345678, 32'h80000008, 4'd2}) begin errors++; $display("[TB] FAIL cen0_word got=%h exp=%h", {qb.out_valid, qb.out_c, qb.out_ill, qb.out_inst, qb.out_npc, qb.count}, {3'b101, 32'h12345678, 32'h80000008, 4'd2}); end
    tick();
    qb.out_ready = 1; qb.in_valid = 1; qb.in_data = 32'h00A00093; #4; tick();
    qb.out_ready = 0; qb.in_valid = 0; #4;
    checks++; if ({qb.out_valid, qb.out_c, qb.out_ill, qb.out_inst, qb.out_pc, qb.count} !== {3'b100, 32'h00A00093, 32'h80000008, 4'd2}) begin errors++; $display("[TB] FAIL cen0_legal got=%h exp=%h", {qb.out_valid, qb.out_c, qb.out_ill, qb.out_inst, qb.out_pc, qb.count}, {3'b100, 32'h00A00093, 32'h80000008, 4'd2}); end
    tick();
  endtask

  // Reference: a plain queue of halfwords in program order, with the PC of its front.
  task automatic test_random();
    logic [15:0] mq[$];
    logic [31:0] m_pc, m_fa, id, rpc, e_inst, e_npc;
    logic        m_skip, iv, ordy, re, e_c, e_v, e_rdy;
    int          e_need;
    idle_all();
    rst = 1; tick(); rst = 0;
    mq.delete(); m_pc = 32'h80000000; m_fa = 32'h80000000; m_skip = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      re   = ($urandom_range(0, 19) == 0);
      id   = $urandom;
      rpc  = $urandom & 32'hFFFFFFFE;
      qa.in_valid = iv; qa.in_data = id; qa.out_ready = ordy; qa.redirect_en = re; qa.redirect_pc = rpc;
      e_rdy  = (mq.size() <= 2);
      e_c    = (mq.size() >= 1) && (mq[0][1:0] != 2'b11);
      e_need = e_c ? 1 : 2;
      e_v    = (mq.size() >= e_need) && !re;
      e_inst = e_c ? {16'h0, mq[0]} : ((mq.size() >= 2) ? {mq[1], mq[0]} : 32'h0);
      e_npc  = m_pc + (e_c ? 32'd2 : 32'd4);
      #4;
      checks++; if ({qa.out_valid, qa.in_ready, qa.out_ill, qa.count, qa.fetch_addr, qa.out_pc} !== {e_v, e_rdy, 1'b0, 3'(mq.size()), m_fa, m_pc}) begin errors++; $display("[TB] FAIL rand_state cyc=%0d got=%h exp=%h", cyc, {qa.out_valid, qa.in_ready, qa.out_ill, qa.count, qa.fetch_addr, qa.out_pc}, {e_v, e_rdy, 1'b0, 3'(mq.size()), m_fa, m_pc}); end
      if (e_v) begin
        checks++; if ({qa.out_c, qa.out_inst, qa.out_npc} !== {e_c, e_inst, e_npc}) begin errors++; $display("[TB] FAIL rand_head cyc=%0d got=%h exp=%h", cyc, {qa.out_c, qa.out_inst, qa.out_npc}, {e_c, e_inst, e_npc}); end
      end
      tick();
      if (re) begin
        mq.delete();
        m_pc = {rpc[31:1], 1'b0}; m_fa = {rpc[31:2], 2'b00}; m_skip = rpc[1];
      end else begin
        if (e_v && ordy) begin
          repeat (e_need) void'(mq.pop_front());
          m_pc = e_npc;
        end
        if (iv && e_rdy) begin
          if (!m_skip) mq.push_back(id[15:0]);
          mq.push_back(id[31:16]);
          m_skip = 0;
          m_fa += 32'd4;
        end
      end
    end
    idle_all();
  endtask

  initial begin
    rst = 1;
    test_reset();
    test_basic();
    test_mixed();
    test_wrap_full();
    test_redirect();
    test_back_to_back();
    test_cen0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
